// File: rtl/bcd_time_keeper_pkg.sv
// Shared BCD limits and helpers for the time-of-day keeper and its digit counters.
// The field maxima mirror the values used by the calibration and alarm blocks.
package bcd_time_keeper_pkg;

  localparam logic [7:0] BCD_SEC_MAX = 8'h59;
  localparam logic [7:0] BCD_MIN_MAX = 8'h59;
  localparam logic [7:0] BCD_HR_MAX  = 8'h23;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sd;
  } bcd_time_t;

  // Both digits must be decimal and the packed value must not exceed the field maximum.
  // Because both digits are decimal, a plain packed compare orders like the decimal value.
  function automatic logic bcd_field_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic bcd_time_ok(input bcd_time_t t);
    return bcd_field_ok(t.hr, BCD_HR_MAX) &&
           bcd_field_ok(t.mn, BCD_MIN_MAX) &&
           bcd_field_ok(t.sd, BCD_SEC_MAX);
  endfunction

  // Increment a packed BCD pair without any binary intermediate; the caller handles wrap at MAX.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] res;
    if (v[3:0] == 4'd9) begin
      res = {v[7:4] + 4'd1, 4'd0};
    end else begin
      res = {v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_time_keeper_counter.sv
// Two-digit packed BCD modulo counter with synchronous load; wraps MAX -> 00 and
// raises a combinational carry on the increment that wraps.
module bcd_mod_counter
  import bcd_time_keeper_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] val,
  output logic       carry
);

  logic [7:0] r_val;
  logic       w_at_max;

  assign w_at_max = (r_val == MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val <= 8'h00;
    end else if (load) begin
      r_val <= load_val;
    end else if (inc) begin
      r_val <= w_at_max ? 8'h00 : bcd_inc(r_val);
    end
  end

  assign val   = r_val;
  assign carry = inc && w_at_max;

endmodule

// File: rtl/bcd_time_keeper.sv
// Free-running hh:mm:ss packed-BCD clock: divides clk to a 1 Hz tick, freezes while the
// user sets the time, and loads the calibrated time on the falling edge of set_mod.
module bcd_time_keeper
  import bcd_time_keeper_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mod,
  input  logic [7:0] hr_cal,
  input  logic [7:0] mn_cal,
  input  logic [7:0] sd_cal,
  output logic [7:0] hr,
  output logic [7:0] mn,
  output logic [7:0] sd,
  output logic       tick_1hz,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int             DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_set_mod_d;
  logic          r_tick;
  logic          r_wrap;
  logic          r_err;

  logic          w_load_req;
  logic          w_cal_ok;
  logic          w_load;
  logic          w_div_last;
  logic          w_tick;
  logic          w_sd_carry;
  logic          w_mn_carry;
  logic          w_hr_carry;
  bcd_time_t     w_cal;

  assign w_cal      = '{hr: hr_cal, mn: mn_cal, sd: sd_cal};
  assign w_load_req = !set_mod && r_set_mod_d;
  assign w_cal_ok   = bcd_time_ok(w_cal);
  assign w_load     = w_load_req && w_cal_ok;
  assign w_div_last = (r_div == DIV_LAST);
  // A load request (valid or not) swallows a tick that falls on the same edge.
  assign w_tick     = !w_load_req && !set_mod && w_div_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_set_mod_d <= 1'b0;
    end else begin
      r_set_mod_d <= set_mod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_load_req || set_mod || w_div_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  bcd_mod_counter #(.MAX(BCD_SEC_MAX)) u_sd (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (sd_cal),
    .inc      (w_tick),
    .val      (sd),
    .carry    (w_sd_carry)
  );

  bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_mn (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (mn_cal),
    .inc      (w_sd_carry),
    .val      (mn),
    .carry    (w_mn_carry)
  );

  bcd_mod_counter #(.MAX(BCD_HR_MAX)) u_hr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (hr_cal),
    .inc      (w_mn_carry),
    .val      (hr),
    .carry    (w_hr_carry)
  );

  // Pulses are registered so they line up with the edge that updates hr/mn/sd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      r_wrap <= w_hr_carry;
      r_err  <= w_load_req && !w_cal_ok;
    end
  end

  assign tick_1hz = r_tick;
  assign day_wrap = r_wrap;
  assign load_err = r_err;

endmodule
